// File: rtl/instr_encoder_loader.sv
// MIPS instruction encoder and program loader: packs one instruction per
// handshake into a 32-bit word and writes it to imem at an auto-incrementing address.
module instr_encoder_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_class,
    input  logic [4:0]            in_rs,
    input  logic [4:0]            in_rt,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_shamt,
    input  logic [5:0]            in_funct,
    input  logic [15:0]           in_imm,
    input  logic [25:0]           in_target,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    input  logic                  imem_ack,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  err_class
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0]   CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [3:0]            CLASS_INVALID = 4'd15;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [ADDR_WIDTH:0]   count_reg;
    logic [ADDR_WIDTH:0]   count_inc;
    logic [31:0]           wdata_reg;
    logic                  err_reg;
    logic [5:0]            opcode;
    logic [31:0]           encoded;
    logic                  valid_class;

    assign valid_class = (in_class != CLASS_INVALID);
    assign count_inc   = count_reg + (ADDR_WIDTH+1)'(1);

    // Opcode lookup and field packing for every instruction class
    always_comb begin
        opcode  = 6'b000000;
        encoded = 32'h0000_0000;
        case (in_class)
            4'd1:    opcode = 6'b001000;
            4'd2:    opcode = 6'b001001;
            4'd3:    opcode = 6'b100011;
            4'd4:    opcode = 6'b101011;
            4'd5:    opcode = 6'b000100;
            4'd6:    opcode = 6'b000101;
            4'd7:    opcode = 6'b000010;
            4'd8:    opcode = 6'b000011;
            4'd10:   opcode = 6'b001101;
            4'd11:   opcode = 6'b001100;
            4'd12:   opcode = 6'b001010;
            4'd13:   opcode = 6'b001011;
            4'd14:   opcode = 6'b001111;
            default: opcode = 6'b000000;
        endcase
        case (in_class)
            4'd0:       encoded = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
            4'd9:       encoded = {6'b000000, in_rs, 15'b0, 6'b001000};
            4'd7, 4'd8: encoded = {opcode, in_target};
            4'd14:      encoded = {opcode, 5'b00000, in_rt, in_imm};
            default:    encoded = {opcode, in_rs, in_rt, in_imm};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid && valid_class) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (imem_ack) begin
                    state_next = (count_inc == CAPACITY) ? FULL : IDLE;
                end
            end
            FULL: begin
                if (start) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // in_ready is masked during reset so the host never sees a handshake that reset discards
    always_comb begin
        in_ready = (state_reg == IDLE) && !rst;
        imem_we  = (state_reg == WRITE);
        full     = (state_reg == FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg  <= BASE;
            count_reg <= '0;
            wdata_reg <= 32'h0000_0000;
            err_reg   <= 1'b0;
        end else begin
            err_reg <= (state_reg == IDLE) && in_valid && !valid_class;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        addr_reg  <= BASE;
                        count_reg <= '0;
                    end
                    if (in_valid && valid_class) begin
                        wdata_reg <= encoded;
                    end
                end
                WRITE: begin
                    if (imem_ack) begin
                        addr_reg  <= addr_reg + ADDR_WIDTH'(1);
                        count_reg <= (count_reg == CAPACITY) ? count_reg : count_inc;
                    end
                end
                FULL: begin
                    if (start) begin
                        addr_reg  <= BASE;
                        count_reg <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_addr  = addr_reg;
    assign imem_wdata = wdata_reg;
    assign count      = count_reg;
    assign err_class  = err_reg;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized self-checking bench for instr_encoder_loader, small 4-word memory
// so that the fill/wrap/rewind path is reached often.
module tb_instr_encoder_loader;

    localparam int AW  = 2;
    localparam int CAP = 4;

    typedef struct packed {
        logic [3:0]  cls;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] tgt;
    } req_t;

    logic          clk = 1'b0;
    logic          rst, start, in_valid, in_ready, imem_we, imem_ack, full, err_class;
    logic [3:0]    in_class;
    logic [4:0]    in_rs, in_rt, in_rd, in_shamt;
    logic [5:0]    in_funct;
    logic [15:0]   in_imm;
    logic [25:0]   in_target;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;

    int total = 0;
    int bad   = 0;
    int exp_addr  = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    instr_encoder_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .imem_ack(imem_ack), .count(count), .full(full), .err_class(err_class)
    );

    // Reference encoding straight from the instruction-format rules
    function automatic logic [31:0] ref_word(req_t r);
        bit [31:0] op, rs, rt, rd, sh, fn, imm, tgt;
        rs = 32'(r.rs); rt = 32'(r.rt); rd = 32'(r.rd); sh = 32'(r.sh);
        fn = 32'(r.fn); imm = 32'(r.imm); tgt = 32'(r.tgt);
        case (r.cls)
            4'd1: op = 8;   4'd2: op = 9;   4'd3: op = 35;  4'd4: op = 43;
            4'd5: op = 4;   4'd6: op = 5;   4'd7: op = 2;   4'd8: op = 3;
            4'd10: op = 13; 4'd11: op = 12; 4'd12: op = 10; 4'd13: op = 11;
            4'd14: op = 15;
            default: op = 0;
        endcase
        if (r.cls == 4'd0)  return (rs << 21) | (rt << 16) | (rd << 11) | (sh << 6) | fn;
        if (r.cls == 4'd9)  return (rs << 21) | 32'd8;
        if (r.cls == 4'd7 || r.cls == 4'd8) return (op << 26) | tgt;
        if (r.cls == 4'd14) return (op << 26) | (rt << 16) | imm;
        return (op << 26) | (rs << 21) | (rt << 16) | imm;
    endfunction

    function automatic req_t rand_req(int cls);
        req_t r;
        r.cls = 4'(cls);     r.rs = 5'($urandom);  r.rt = 5'($urandom);
        r.rd = 5'($urandom); r.sh = 5'($urandom);  r.fn = 6'($urandom);
        r.imm = 16'($urandom); r.tgt = 26'($urandom);
        return r;
    endfunction

    task automatic drive(req_t r);
        in_class = r.cls; in_rs = r.rs; in_rt = r.rt; in_rd = r.rd;
        in_shamt = r.sh;  in_funct = r.fn; in_imm = r.imm; in_target = r.tgt;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_addr  = 0;
        exp_count = 0;
    endtask

    // Issue one request, stall `stall` cycles, then ack; report what was observed
    task automatic xfer(input req_t r, input int stall, output logic we_o,
                        output logic [AW-1:0] addr_o, output logic [31:0] data_o,
                        output logic stable_o, output logic [AW:0] cnt_o,
                        output logic rdy_o, output logic full_o);
        drive(r);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        drive(rand_req(int'($urandom_range(0, 15))));
        we_o = imem_we; addr_o = imem_addr; data_o = imem_wdata; stable_o = 1'b1;
        repeat (stall) begin
            @(negedge clk);
            if (imem_we !== 1'b1 || imem_addr !== addr_o || imem_wdata !== data_o) stable_o = 1'b0;
        end
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        cnt_o = count; rdy_o = in_ready; full_o = full;
        exp_addr  = (exp_addr + 1) % CAP;
        exp_count = (exp_count < CAP) ? exp_count + 1 : CAP;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; imem_ack = 1'b0;
        drive(rand_req(0));
        repeat (2) @(negedge clk);
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_cycle_ready got=%b want=0", in_ready); end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({in_ready, imem_we, err_class, full, count, imem_wdata, imem_addr} !== {4'b1000, 3'd0, 32'd0, 2'd0}) begin
            bad++;
            $display("FAIL reset_values got rdy=%b we=%b err=%b full=%b cnt=%0d wd=%h addr=%0d want rdy=1 rest=0",
                     in_ready, imem_we, err_class, full, count, imem_wdata, imem_addr);
        end
        exp_addr = 0; exp_count = 0;
    endtask

    task automatic test_addi();
        req_t r; logic we; logic [AW-1:0] a; logic [31:0] d; logic st, rdy, fl; logic [AW:0] c;
        r = rand_req(1); r.rs = 5'd0; r.rt = 5'd8; r.imm = 16'h0005;
        xfer(r, 0, we, a, d, st, c, rdy, fl);
        total++; if (we !== 1'b1) begin bad++; $display("FAIL addi_we got=%b want=1", we); end
        total++; if (a !== 2'd0) begin bad++; $display("FAIL addi_addr got=%0d want=0", a); end
        total++; if (d !== 32'h20080005) begin bad++; $display("FAIL addi_word got=%h want=20080005", d); end
        total++; if (c !== 3'd1 || rdy !== 1'b1) begin bad++; $display("FAIL addi_after got cnt=%0d rdy=%b want cnt=1 rdy=1", c, rdy); end
    endtask

    task automatic test_back_to_back();
        req_t r; logic we; logic [AW-1:0] a; logic [31:0] d; logic st, rdy, fl; logic [AW:0] c;
        do_start();
        r = rand_req(0); r.rs = 5'd8; r.rt = 5'd9; r.rd = 5'd10; r.sh = 5'd0; r.fn = 6'h20;
        xfer(r, 0, we, a, d, st, c, rdy, fl);
        total++; if (a !== 2'd0 || d !== 32'h01095020) begin bad++; $display("FAIL rtype got addr=%0d word=%h want addr=0 word=01095020", a, d); end
        r = rand_req(5); r.rs = 5'd8; r.rt = 5'd9; r.imm = 16'hFFFF;
        xfer(r, 0, we, a, d, st, c, rdy, fl);
        total++; if (a !== 2'd1 || d !== 32'h1109FFFF) begin bad++; $display("FAIL beq got addr=%0d word=%h want addr=1 word=1109ffff", a, d); end
        total++; if (c !== 3'd2) begin bad++; $display("FAIL b2b_count got=%0d want=2", c); end
    endtask

    task automatic test_jumps();
        req_t r; logic we; logic [AW-1:0] a; logic [31:0] d; logic st, rdy, fl; logic [AW:0] c;
        do_start();
        r = rand_req(8); r.tgt = 26'h0000010;
        xfer(r, 0, we, a, d, st, c, rdy, fl);
        total++; if (d !== 32'h0C000010) begin bad++; $display("FAIL jal_word got=%h want=0c000010", d); end
        r = rand_req(9); r.rs = 5'd31; r.fn = 6'h3F;
        xfer(r, 0, we, a, d, st, c, rdy, fl);
        total++; if (d !== 32'h03E00008) begin bad++; $display("FAIL jr_word got=%h want=03e00008", d); end
        r = rand_req(14); r.rs = 5'd7; r.rt = 5'd1; r.imm = 16'h1234;
        xfer(r, 1, we, a, d, st, c, rdy, fl);
        total++; if (d !== 32'h3C011234 || a !== 2'd2) begin bad++; $display("FAIL lui got word=%h addr=%0d want word=3c011234 addr=2", d, a); end
    endtask

    task automatic test_invalid();
        logic [AW:0] c0;
        c0 = count;
        drive(rand_req(15));
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (err_class !== 1'b1 || imem_we !== 1'b0) begin bad++; $display("FAIL invalid_pulse got err=%b we=%b want err=1 we=0", err_class, imem_we); end
        @(negedge clk);
        total++; if (err_class !== 1'b0 || imem_we !== 1'b0) begin bad++; $display("FAIL invalid_after got err=%b we=%b want 0 0", err_class, imem_we); end
        total++; if (count !== 3'(exp_count) || count !== c0 || in_ready !== 1'b1) begin bad++; $display("FAIL invalid_count got cnt=%0d rdy=%b want cnt=%0d rdy=1", count, in_ready, exp_count); end
    endtask

    task automatic test_stall_reset();
        req_t r; logic [AW-1:0] a; logic [31:0] d; logic st;
        r = rand_req(int'($urandom_range(0, 14)));
        drive(r);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = imem_addr; d = imem_wdata; st = imem_we;
        total++; if (a !== 2'(exp_addr) || d !== ref_word(r)) begin bad++; $display("FAIL stall_first got addr=%0d word=%h want addr=%0d word=%h", a, d, exp_addr, ref_word(r)); end
        repeat (5) begin
            @(negedge clk);
            if (imem_we !== 1'b1 || imem_addr !== a || imem_wdata !== d) st = 1'b0;
        end
        total++; if (st !== 1'b1) begin bad++; $display("FAIL stall_stable got=%b want=1", st); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (imem_we !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL reset_midwrite got we=%b cnt=%0d want we=0 cnt=0", imem_we, count); end
        rst = 1'b0;
        @(negedge clk);
        exp_addr = 0; exp_count = 0;
        total++; if (in_ready !== 1'b1 || imem_addr !== 2'd0) begin bad++; $display("FAIL reset_recover got rdy=%b addr=%0d want 1 0", in_ready, imem_addr); end
    endtask

    task automatic test_fill();
        req_t r; logic we; logic [AW-1:0] a; logic [31:0] d; logic st, rdy, fl; logic [AW:0] c;
        int ea;
        do_start();
        for (int i = 0; i < CAP; i++) begin
            r = rand_req(int'($urandom_range(0, 14)));
            ea = exp_addr;
            xfer(r, 0, we, a, d, st, c, rdy, fl);
            total++; if (a !== 2'(ea) || d !== ref_word(r)) begin bad++; $display("FAIL fill_write%0d got addr=%0d word=%h want addr=%0d word=%h", i, a, d, ea, ref_word(r)); end
        end
        total++; if (c !== 3'd4 || fl !== 1'b1 || rdy !== 1'b0 || imem_addr !== 2'd0) begin
            bad++; $display("FAIL fill_full got cnt=%0d full=%b rdy=%b addr=%0d want 4 1 0 0", c, fl, rdy, imem_addr);
        end
        drive(rand_req(1)); in_valid = 1'b1; imem_ack = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0; imem_ack = 1'b0;
        total++; if (imem_we !== 1'b0 || count !== 3'd4 || full !== 1'b1) begin bad++; $display("FAIL full_hold got we=%b cnt=%0d full=%b want 0 4 1", imem_we, count, full); end
        do_start();
        total++; if (full !== 1'b0 || in_ready !== 1'b1 || count !== 3'd0) begin bad++; $display("FAIL rewind got full=%b rdy=%b cnt=%0d want 0 1 0", full, in_ready, count); end
        r = rand_req(3);
        xfer(r, 0, we, a, d, st, c, rdy, fl);
        total++; if (a !== 2'd0 || d !== ref_word(r) || c !== 3'd1) begin bad++; $display("FAIL rewind_write got addr=%0d word=%h cnt=%0d want 0 %h 1", a, d, c, ref_word(r)); end
    endtask

    task automatic test_start_with_valid();
        req_t r;
        r = rand_req(4);
        drive(r);
        start = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        exp_addr = 0; exp_count = 0;
        total++; if (imem_we !== 1'b1 || imem_addr !== 2'd0 || imem_wdata !== ref_word(r)) begin
            bad++; $display("FAIL start_valid got we=%b addr=%0d word=%h want 1 0 %h", imem_we, imem_addr, imem_wdata, ref_word(r));
        end
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        exp_addr = 1; exp_count = 1;
        total++; if (count !== 3'd1 || imem_addr !== 2'd1) begin bad++; $display("FAIL start_valid_after got cnt=%0d addr=%0d want 1 1", count, imem_addr); end
    endtask

    task automatic test_random();
        req_t r; logic we; logic [AW-1:0] a; logic [31:0] d; logic st, rdy, fl; logic [AW:0] c;
        int ea;
        for (int i = 0; i < 40; i++) begin
            if (exp_count == CAP) do_start();
            r = rand_req(int'($urandom_range(0, 14)));
            ea = exp_addr;
            xfer(r, int'($urandom_range(0, 3)), we, a, d, st, c, rdy, fl);
            total++;
            if (we !== 1'b1 || st !== 1'b1 || a !== 2'(ea) || d !== ref_word(r) || c !== 3'(exp_count)
                || fl !== (exp_count == CAP) || rdy !== (exp_count != CAP)) begin
                bad++;
                $display("FAIL random%0d got we=%b stable=%b addr=%0d word=%h cnt=%0d full=%b rdy=%b want addr=%0d word=%h cnt=%0d",
                         i, we, st, a, d, c, fl, rdy, ea, ref_word(r), exp_count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_jumps();
        test_invalid();
        test_stall_reset();
        test_fill();
        test_start_with_valid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
